// File: rtl/fifo_pkg.sv
// fifo_pkg - shared definitions for the dual-clock FIFO pointer controllers.
//   SYNC_MIN      : smallest legal synchroniser depth.
//   fwft_state_t  : output-register state for first-word-fall-through reads.
//   bin2gray/gray2bin : code conversion on a zero-extended GW-bit vector.
//     A zero-extended value converts correctly at any narrower width, so
//     callers cast in and truncate out to their own pointer width.
package fifo_pkg;

    localparam int SYNC_MIN = 2;
    localparam int GW       = 32;

    typedef enum logic [1:0] {IDLE, PEND, HOLD} fwft_state_t;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_ctl_if.sv
// rd_ptr_ctl_if - user and RAM read-side signals of the FIFO read controller.
//   master : the controller (drives RAM strobe/address and user status/data).
//   slave  : the user logic plus RAM read port.
interface rd_ptr_ctl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic              rd_err_clr;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty;
    logic              rd_almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              rd_underflow;

    modport master (
        input  rd_en, rd_err_clr, ram_rd_data,
        output ram_rd_en, ram_rd_addr, rd_data, rd_valid, rd_empty,
               rd_almost_empty, rd_level, rd_underflow
    );

    modport slave (
        output rd_en, rd_err_clr, ram_rd_data,
        input  ram_rd_en, ram_rd_addr, rd_data, rd_valid, rd_empty,
               rd_almost_empty, rd_level, rd_underflow
    );
endinterface

// File: rtl/ptr_sync.sv
// ptr_sync - multi-flop synchroniser for a Gray-coded FIFO pointer.
//   clk, rst_n : destination clock, async active-low reset.
//   d          : Gray pointer from the other clock domain.
//   q          : synchronised pointer (last stage).
// Depths below SYNC_MIN are raised to SYNC_MIN.
module ptr_sync
    import fifo_pkg::*;
#(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    localparam int N = (STAGES < SYNC_MIN) ? SYNC_MIN : STAGES;

    logic [N-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[N-2:0], d};
    end

    assign q = sr[N-1];
endmodule

// File: rtl/rd_ptr_ctl.sv
// rd_ptr_ctl - read-domain pointer and flag controller for a dual-clock FIFO.
//   rd_clk, rd_rst_n : read clock, async active-low reset.
//   wr_ptr_gray      : write pointer (Gray) from the write domain.
//   rd_ptr_gray      : registered read pointer (Gray) to the write domain.
//   bus              : user read port, status flags and RAM read port.
// FWFT=0: rd_data passes RAM data through, rd_valid follows an accepted read.
// FWFT=1: a small FSM prefetches into an output register; rd_en pops it.
module rd_ptr_ctl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1,
    parameter int FWFT        = 0
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    rd_ptr_ctl_if.master      bus
);
    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wsync_gray, wbin;
    logic [PW-1:0] rd_bin, rd_bin_next, gray_next, level_next;
    logic [PW-1:0] level_q;
    logic          ptr_empty, ae_q, underflow_q;
    logic          req, fetch, empty_int;

    ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d     (wr_ptr_gray),
        .q     (wsync_gray)
    );

    assign wbin        = PW'(gray2bin(GW'(wsync_gray)));
    assign fetch       = !ptr_empty && req;
    assign rd_bin_next = rd_bin + PW'(fetch);
    assign gray_next   = PW'(bin2gray(GW'(rd_bin_next)));
    // Unsigned modulo difference; MSB set only when exactly full.
    assign level_next  = wbin - rd_bin_next;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            ptr_empty   <= 1'b1;
            level_q     <= '0;
            ae_q        <= 1'b1;
        end else begin
            rd_bin      <= rd_bin_next;
            rd_ptr_gray <= gray_next;
            // Full-width compare (wrap bit included) separates empty from full.
            ptr_empty   <= (gray_next == wsync_gray);
            level_q     <= level_next;
            ae_q        <= (level_next <= PW'(AE_THRESH));
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n)                   underflow_q <= 1'b0;
        else if (bus.rd_err_clr)         underflow_q <= 1'b0;
        else if (bus.rd_en && empty_int) underflow_q <= 1'b1;
    end

    assign bus.ram_rd_en       = fetch;
    assign bus.ram_rd_addr     = rd_bin[ADDR_W-1:0];
    assign bus.rd_level        = level_q;
    assign bus.rd_almost_empty = ae_q;
    assign bus.rd_underflow    = underflow_q;
    assign bus.rd_empty        = empty_int;

    generate
        if (FWFT != 0) begin : g_fwft
            fwft_state_t       state, state_nxt;
            logic              fwft_req;
            logic [DATA_W-1:0] dreg;

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    state <= IDLE;
                    dreg  <= '0;
                end else begin
                    state <= state_nxt;
                    // RAM data for the fetch issued in the previous cycle.
                    if (state == PEND) dreg <= bus.ram_rd_data;
                end
            end

            always_comb begin
                state_nxt = state;
                fwft_req  = 1'b0;
                case (state)
                    IDLE: begin
                        fwft_req = 1'b1;
                        if (!ptr_empty) state_nxt = PEND;
                    end
                    PEND: state_nxt = HOLD;
                    HOLD: begin
                        if (bus.rd_en) begin
                            fwft_req  = 1'b1;
                            state_nxt = ptr_empty ? IDLE : PEND;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end

            assign req          = fwft_req;
            assign bus.rd_data  = dreg;
            assign bus.rd_valid = (state == HOLD);
            assign empty_int    = (state != HOLD);
        end else begin : g_std
            logic valid_q;

            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) valid_q <= 1'b0;
                else           valid_q <= fetch;
            end

            assign req          = bus.rd_en;
            assign bus.rd_data  = bus.ram_rd_data;
            assign bus.rd_valid = valid_q;
            assign empty_int    = ptr_empty;
        end
    endgenerate
endmodule

// File: tb/tb_rd_ptr_ctl.sv
// tb_rd_ptr_ctl - directed bench: one standard-mode and one FWFT-mode
// controller on a shared clock/reset, each with a 1-cycle-latency RAM model.
module tb_rd_ptr_ctl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] wpa, rpa, wpb, rpb;
    logic [7:0] mem_a [8];
    logic [7:0] mem_b [8];

    rd_ptr_ctl_if #(.ADDR_W(3), .DATA_W(8)) ba ();
    rd_ptr_ctl_if #(.ADDR_W(3), .DATA_W(8)) bb ();

    rd_ptr_ctl #(.ADDR_W(3), .DATA_W(8), .SYNC_STAGES(2), .AE_THRESH(1), .FWFT(0)) dut_a (
        .rd_clk(clk), .rd_rst_n(rst_n), .wr_ptr_gray(wpa), .rd_ptr_gray(rpa), .bus(ba));
    rd_ptr_ctl #(.ADDR_W(3), .DATA_W(8), .SYNC_STAGES(2), .AE_THRESH(1), .FWFT(1)) dut_b (
        .rd_clk(clk), .rd_rst_n(rst_n), .wr_ptr_gray(wpb), .rd_ptr_gray(rpb), .bus(bb));

    always @(posedge clk) if (ba.ram_rd_en) ba.ram_rd_data <= mem_a[ba.ram_rd_addr];
    always @(posedge clk) if (bb.ram_rd_en) bb.ram_rd_data <= mem_b[bb.ram_rd_addr];

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    int wb, rb;
    int batch [2] = '{8, 7};

    initial begin
        rst_n = 1'b0;
        wpa = '0; wpb = '0;
        ba.rd_en = 1'b0; ba.rd_err_clr = 1'b0;
        bb.rd_en = 1'b0; bb.rd_err_clr = 1'b0;
        step(); step();

        // reset state
        chk("a_rst_empty", 32'(ba.rd_empty), 1);
        chk("a_rst_ae",    32'(ba.rd_almost_empty), 1);
        chk("a_rst_level", 32'(ba.rd_level), 0);
        chk("a_rst_rptr",  32'(rpa), 0);
        chk("a_rst_uf",    32'(ba.rd_underflow), 0);
        chk("b_rst_empty", 32'(bb.rd_empty), 1);
        chk("b_rst_valid", 32'(bb.rd_valid), 0);
        chk("b_rst_data",  32'(bb.rd_data), 0);
        rst_n = 1'b1;
        step();

        // underflow on empty FIFO, pointer must not move
        ba.rd_en = 1'b1;
        #1 chk("a_uf_no_fetch", 32'(ba.ram_rd_en), 0);
        step(); step(); step();
        chk("a_uf_set",  32'(ba.rd_underflow), 1);
        chk("a_uf_rptr", 32'(rpa), 0);
        chk("a_uf_addr", 32'(ba.ram_rd_addr), 0);
        ba.rd_en = 1'b0; ba.rd_err_clr = 1'b1;
        step();
        chk("a_uf_clr", 32'(ba.rd_underflow), 0);
        ba.rd_err_clr = 1'b0;

        // standard mode: 5 words visible
        for (int i = 0; i < 5; i++) mem_a[i] = 8'(8'h10 + i);
        wpa = 4'b0111;
        step(); step();
        chk("a_sync_still_empty", 32'(ba.rd_empty), 1);
        step();
        chk("a_lvl5",   32'(ba.rd_level), 5);
        chk("a_nempty", 32'(ba.rd_empty), 0);
        chk("a_ae_l5",  32'(ba.rd_almost_empty), 0);
        for (int i = 0; i < 5; i++) begin
            ba.rd_en = 1'b1;
            #1;
            chk("a_rd_en",   32'(ba.ram_rd_en), 1);
            chk("a_rd_addr", 32'(ba.ram_rd_addr), 32'(i));
            step();
            chk("a_valid", 32'(ba.rd_valid), 1);
            chk("a_data",  32'(ba.rd_data), 32'(8'h10 + i));
            chk("a_level", 32'(ba.rd_level), 32'(4 - i));
            chk("a_ae",    32'(ba.rd_almost_empty), ((4 - i) <= 1) ? 1 : 0);
        end
        ba.rd_en = 1'b0;
        chk("a_drain_empty", 32'(ba.rd_empty), 1);
        chk("a_drain_rptr",  32'(rpa), 32'(4'b0111));
        step();
        chk("a_valid_drop", 32'(ba.rd_valid), 0);

        // wrap: 15 more words in batches of 8 then 7 (20 total)
        wb = 5; rb = 5;
        foreach (batch[j]) begin
            for (int k = 0; k < batch[j]; k++) mem_a[(wb + k) % 8] = 8'(8'h30 + wb + k);
            wb += batch[j];
            wpa = g4(wb);
            step(); step();
            chk("w_pre_empty", 32'(ba.rd_empty), 1);
            step();
            chk("w_level", 32'(ba.rd_level), 32'(batch[j]));
            for (int k = 0; k < batch[j]; k++) begin
                ba.rd_en = 1'b1;
                #1 chk("w_addr", 32'(ba.ram_rd_addr), 32'(rb % 8));
                step();
                chk("w_data", 32'(ba.rd_data), 32'(8'(8'h30 + rb)));
                rb++;
            end
            ba.rd_en = 1'b0;
            chk("w_drain_empty", 32'(ba.rd_empty), 1);
            chk("w_drain_level", 32'(ba.rd_level), 0);
        end
        chk("w_final_rptr", 32'(rpa), 32'(4'b0110));
        chk("w_final_addr", 32'(ba.ram_rd_addr), 4);

        // clear has priority over set; then sticky set
        ba.rd_en = 1'b1; ba.rd_err_clr = 1'b1;
        step();
        chk("clr_prio", 32'(ba.rd_underflow), 0);
        ba.rd_err_clr = 1'b0;
        step();
        chk("uf_set2", 32'(ba.rd_underflow), 1);
        ba.rd_en = 1'b0;
        step();
        chk("uf_sticky", 32'(ba.rd_underflow), 1);
        ba.rd_err_clr = 1'b1;
        step();
        chk("uf_clr2", 32'(ba.rd_underflow), 0);
        ba.rd_err_clr = 1'b0;

        // FWFT: two words A1, B2
        mem_b[0] = 8'hA1; mem_b[1] = 8'hB2; mem_b[2] = 8'hC3;
        wpb = 4'b0011;
        step(); step();
        chk("f_pre_valid", 32'(bb.rd_valid), 0);
        step();
        chk("f_fetch0", 32'(bb.ram_rd_en), 1);
        chk("f_lvl2",   32'(bb.rd_level), 2);
        step();
        chk("f_pend_valid", 32'(bb.rd_valid), 0);
        chk("f_pend_empty", 32'(bb.rd_empty), 1);
        chk("f_lvl1",       32'(bb.rd_level), 1);
        step();
        chk("f_valid_a1", 32'(bb.rd_valid), 1);
        chk("f_data_a1",  32'(bb.rd_data), 32'(8'hA1));
        chk("f_nempty",   32'(bb.rd_empty), 0);
        step();
        chk("f_hold_data", 32'(bb.rd_data), 32'(8'hA1));
        chk("f_hold_vld",  32'(bb.rd_valid), 1);
        bb.rd_en = 1'b1;
        #1;
        chk("f_pop_fetch", 32'(bb.ram_rd_en), 1);
        chk("f_pop_addr",  32'(bb.ram_rd_addr), 1);
        step();
        bb.rd_en = 1'b0;
        chk("f_pop_pend", 32'(bb.rd_valid), 0);
        step();
        chk("f_valid_b2", 32'(bb.rd_valid), 1);
        chk("f_data_b2",  32'(bb.rd_data), 32'(8'hB2));
        chk("f_lvl0",     32'(bb.rd_level), 0);
        bb.rd_en = 1'b1;
        #1 chk("f_pop2_nofetch", 32'(bb.ram_rd_en), 0);
        step();
        bb.rd_en = 1'b0;
        chk("f_pop2_valid", 32'(bb.rd_valid), 0);
        chk("f_pop2_empty", 32'(bb.rd_empty), 1);
        chk("f_pop2_uf",    32'(bb.rd_underflow), 0);
        step();
        chk("f_idle_nofetch", 32'(bb.ram_rd_en), 0);
        chk("f_idle_empty",   32'(bb.rd_empty), 1);
        chk("f_rptr",         32'(rpb), 32'(4'b0011));

        // async reset while a fetch is pending
        wpb = g4(3);
        step(); step(); step(); step();
        chk("f_pend2_rptr", 32'(rpb), 32'(4'b0010));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_b_valid", 32'(bb.rd_valid), 0);
        chk("ar_b_empty", 32'(bb.rd_empty), 1);
        chk("ar_b_rptr",  32'(rpb), 0);
        chk("ar_b_addr",  32'(bb.ram_rd_addr), 0);
        chk("ar_a_rptr",  32'(rpa), 0);
        chk("ar_a_empty", 32'(ba.rd_empty), 1);
        wpa = '0; wpb = '0;
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
